// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: data width, requester indices and the
// UART TX scheduler state encoding.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;

  // Requester indices into the scheduler's per-requester ports.
  localparam int UART_TX_REQ_CPU = 0;
  localparam int UART_TX_REQ_HW  = 1;

  // Scheduler FSM encoding. The state values are kept as plain constants
  // so that older blocks can compare against them directly.
  typedef logic [1:0] uart_tx_sched_state_e;

  localparam uart_tx_sched_state_e ST_IDLE      = 2'd0;
  localparam uart_tx_sched_state_e ST_START     = 2'd1;
  localparam uart_tx_sched_state_e ST_WAIT_BUSY = 2'd2;
  localparam uart_tx_sched_state_e ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the shared UART TX path.
// Occupancy is tracked with an explicit counter; full/empty come from it so
// the pointers can wrap naturally. DEPTH must be a power of two, >= 2.
// Flush has priority over push and pop.
module uart_tx_fifo
  import arch_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array, written on an accepted push; no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmitter between the CPU write path (requester 0) and
// the hardware trace source (requester 1). Accepted bytes go through a
// shared FIFO in strict arrival order; the FSM issues one start strobe per
// byte and waits for the transmitter's busy handshake.
//
// Build option: UART_TX_FIXED_PRIO_EN -- when defined, the CPU requester
// always wins contention and no round-robin state is built.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a byte; pops FIFO head into tx_data
// ST_START     | tx_start asserted for exactly this cycle
// ST_WAIT_BUSY | waiting for tx_busy to rise; times out into tx_err
// ST_WAIT_DONE | transmitter busy; waiting for tx_busy to fall
module uart_tx_scheduler
  import arch_defs_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        req_valid,
  input  logic [1:0][DATA_WIDTH-1:0]        req_data,
  output logic [1:0]                        req_ready,
  input  logic                              flush,
  output logic [DATA_WIDTH-1:0]             tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              fifo_full,
  output logic                              tx_err,
  output logic                              idle
);

  localparam int TMR_W = $clog2(START_TIMEOUT+1);

  uart_tx_sched_state_e  state;
  logic [TMR_W-1:0]      tmr;
  logic [1:0]            grant;
  logic                  push;
  logic                  push_sel;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  timeout;

`ifdef UART_TX_FIXED_PRIO_EN
  // Fixed priority: the CPU requester wins whenever it is valid.
  always_comb begin
    grant = '0;
    if (req_valid[UART_TX_REQ_CPU]) begin
      grant[UART_TX_REQ_CPU] = 1'b1;
    end else if (req_valid[UART_TX_REQ_HW]) begin
      grant[UART_TX_REQ_HW] = 1'b1;
    end
  end
`else
  // Requester preferred at the next contention; moves only on a real push.
  logic rr_pref;

  // Round-robin: a lone requester is granted, contention goes to rr_pref.
  always_comb begin
    grant = '0;
    if (req_valid == 2'b11) begin
      grant[rr_pref] = 1'b1;
    end else begin
      grant = req_valid;
    end
  end

  // Prefer the other requester after each accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_pref <= 1'(UART_TX_REQ_CPU);
    end else if (push) begin
      rr_pref <= ~push_sel;
    end
  end
`endif

  assign req_ready = (fifo_full || flush) ? 2'b00 : grant;
  assign push      = |(req_valid & req_ready);
  assign push_sel  = req_ready[UART_TX_REQ_HW];
  assign push_data = req_data[push_sel];

  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign timeout  = (state == ST_WAIT_BUSY) && !tx_busy && (tmr == '0);
  assign tx_start = (state == ST_START);
  assign idle     = fifo_empty && (state == ST_IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Start sequencing FSM with a down-counting busy timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT_BUSY;
          tmr   <= TMR_W'(START_TIMEOUT-1);
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmr == '0) begin
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // tx_data holds the last popped byte; a flush does not disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data <= '0;
    end else if (pop) begin
      tx_data <= fifo_head;
    end
  end

  // Sticky timeout error, cleared only by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_err <= 1'b0;
    end else if (flush) begin
      tx_err <= 1'b0;
    end else if (timeout) begin
      tx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed stimulus, expected transmit bytes
// queued in a scoreboard and checked by a monitor on every start strobe.
module tb_uart_tx_scheduler;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_data;
  logic [1:0]       req_ready;
  logic             flush;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [2:0]       fifo_count;
  logic             fifo_full;
  logic             tx_err;
  logic             idle;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  // transmitter model: 0 = respond (busy one cycle after start, 3 cycles),
  // 1 = busy held high, 2 = busy never rises
  int busy_mode = 0;
  int busy_left = 0;
  bit pend      = 0;

  uart_tx_scheduler #(.FIFO_DEPTH(4), .START_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .flush      (flush),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .tx_err     (tx_err),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transmitter model
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0; pend = 0; busy_left = 0;
      end else if (busy_mode == 0) begin
        if (tx_busy) begin
          if (busy_left == 0) tx_busy = 1'b0;
          else busy_left--;
        end else if (pend) begin
          tx_busy = 1'b1; busy_left = 2; pend = 0;
        end
        if (tx_start) pend = 1;
      end else if (busy_mode == 1) begin
        tx_busy = 1'b1;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // scoreboard monitor: every start strobe must match the next expected byte
  initial begin
    logic prev_start;
    logic [7:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        chk("start_one_cycle", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e));
        end
      end
      prev_start = rst_n ? tx_start : 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; req_data = '0; flush = 1'b0;
    busy_mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_idle",  32'(idle), 32'd1);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    chk("rst_err",   32'(tx_err), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic send(input int r, input logic [7:0] d);
    int n = 0;
    req_valid[r] = 1'b1; req_data[r] = d;
    #1;
    while (!req_ready[r] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready[r]) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!idle && n < 200) begin
      @(negedge clk); n++;
    end
    chk(nm, 32'(idle), 32'd1);
  endtask

  initial begin
    logic [1:0] g;
    int a_n, b_n, acc;
    bit full_seen;
    rst_n = 1'b1; req_valid = 2'b00; req_data = '0; flush = 1'b0;
    #2;
    do_reset();

    // single byte and latency
    exp_q.push_back(8'h41);
    send(0, 8'h41);
    chk("lat_e0_start", 32'(tx_start), 32'd0);
    chk("lat_e0_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("lat_e1_start", 32'(tx_start), 32'd1);
    chk("lat_e1_data",  32'(tx_data), 32'h41);
    chk("lat_e1_count", 32'(fifo_count), 32'd0);
    wait_idle("single_idle");

    // arbitration order, fill to full, fifth/sixth byte waits for pop
    do_reset();
`ifdef UART_TX_FIXED_PRIO_EN
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`else
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
    busy_mode = 1;
    req_valid = 2'b11; a_n = 0; b_n = 0; acc = 0; full_seen = 0;
    for (int cyc = 0; cyc < 80 && acc < 6; cyc++) begin
      req_data[0] = 8'(8'hA0 + a_n);
      req_data[1] = 8'(8'hB0 + b_n);
      #1;
      if (fifo_full && !full_seen) begin
        full_seen = 1;
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_ready", 32'(req_ready), 32'd0);
        chk("fill_accepts", 32'(acc), 32'd5);
        busy_left = 0; pend = 0; busy_mode = 0;
      end
      g = req_ready;
      @(posedge clk);
      if (g[0]) begin a_n++; acc++; end
      else if (g[1]) begin b_n++; acc++; end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("fill_seen", 32'(full_seen), 32'd1);
    chk("total_accepts", 32'(acc), 32'd6);
    wait_idle("arb_idle");

    // start timeout
    do_reset();
    busy_mode = 2;
    exp_q.push_back(8'h55);
    send(0, 8'h55);
    repeat (5) @(negedge clk);
    chk("tmo_err_before", 32'(tx_err), 32'd0);
    @(negedge clk);
    chk("tmo_err_set", 32'(tx_err), 32'd1);
    chk("tmo_idle", 32'(idle), 32'd1);
    busy_mode = 0;
    exp_q.push_back(8'h66);
    send(1, 8'h66);
    wait_idle("tmo_next_idle");
    chk("tmo_err_sticky", 32'(tx_err), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("tmo_err_flushed", 32'(tx_err), 32'd0);

    // flush with three bytes queued behind an in-flight byte
    do_reset();
    busy_mode = 1;
    exp_q.push_back(8'hC0);
    send(1, 8'hC0);
    send(1, 8'hC1);
    send(1, 8'hC2);
    send(1, 8'hC3);
    chk("flush_pre_count", 32'(fifo_count), 32'd3);
    flush = 1'b1; req_valid[0] = 1'b1; req_data[0] = 8'hEE;
    #1;
    chk("flush_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 2'b00;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_data_kept", 32'(tx_data), 32'hC0);
    busy_left = 0; pend = 0; busy_mode = 0;
    wait_idle("flush_idle");
    repeat (10) @(negedge clk);
    chk("flush_quiet_idle", 32'(idle), 32'd1);

    // asynchronous reset during WAIT_DONE
    do_reset();
    busy_mode = 1;
    exp_q.push_back(8'h77);
    send(0, 8'h77);
    send(1, 8'h78);
    repeat (3) @(negedge clk);
    chk("ar_pre_data", 32'(tx_data), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_start", 32'(tx_start), 32'd0);
    chk("ar_data",  32'(tx_data), 32'd0);
    chk("ar_idle",  32'(idle), 32'd1);
    chk("ar_count", 32'(fifo_count), 32'd0);
    chk("ar_full",  32'(fifo_full), 32'd0);
    busy_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("ar_after_idle", 32'(idle), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
